// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive-state encoding and default frame constants
package uart_pkg;
  localparam int DATA_WIDTH_DEF   = 8;
  localparam int CLKS_PER_BIT_DEF = 16;
  typedef enum logic [2:0] {HUNT, IDLE, START, DATA, STOP} rx_state_e;
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: AXI-stream style word channel from the receiver to its consumer
interface uart_rx_if import uart_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  modport master (output tdata, tvalid, input tready);
  modport slave  (input tdata, tvalid, output tready);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous single-bit input
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s1_q, s2_q;
  // metastability chain, both stages reset to the idle line level
  always_ff @(posedge clk) begin
    s1_q <= rst ? RESET_VAL : d;
    s2_q <= rst ? RESET_VAL : s1_q;
  end
  assign q = s2_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1-style serial receiver presenting words on a valid/ready master
module uart_rx import uart_pkg::*; #(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rxd,
  uart_rx_if.master m_axis,
  output logic      busy,
  output logic      frame_error,
  output logic      overrun_error
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST = IW'(DATA_WIDTH - 1);

  if (CLKS_PER_BIT % 2 != 0 || CLKS_PER_BIT < 4) begin : g_bad_cpb
    $error("uart_rx: CLKS_PER_BIT must be even and >= 4");
  end

  logic                  rxd_s, tick, good, accept, load;
  rx_state_e             state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, tdata_q, tdata_d;
  logic [1:0]            hist_q, hist_d;
  logic                  done_q, done_d, tvalid_q, tvalid_d;
  logic                  ferr_q, ferr_d, ovr_q, ovr_d;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(rxd), .q(rxd_s));

  assign tick = cnt_q == '0;

  // hist_q also needs three consecutive highs before HUNT releases, so the
  // reset-value ones still draining out of the synchroniser are not trusted
  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? cnt_q : cnt_q - 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    hist_d  = {hist_q[0], rxd_s};
    done_d  = 1'b0;
    case (state_q)
      HUNT:  state_d = (rxd_s && &hist_q) ? IDLE : HUNT;
      IDLE:  if (!rxd_s) begin
               state_d = START;
               cnt_d   = HALF;
             end
      START: if (tick) begin
               state_d = rxd_s ? IDLE : DATA;
               cnt_d   = FULL;
               idx_d   = '0;
             end
      DATA:  if (tick) begin
               shift_d[idx_q[IW-2:0]] = rxd_s;
               cnt_d   = FULL;
               idx_d   = (idx_q == LAST) ? idx_q : idx_q + 1'b1;
               state_d = (idx_q == LAST) ? STOP : DATA;
             end
      STOP:  if (tick) begin
               state_d = rxd_s ? IDLE : HUNT;
               done_d  = 1'b1;
             end
      default: state_d = HUNT;
    endcase
  end

  // output stage one cycle after the stop sample; hist_q[0] holds that sample
  always_comb begin
    good     = done_q && hist_q[0];
    accept   = tvalid_q && m_axis.tready;
    load     = good && (!tvalid_q || m_axis.tready);
    tvalid_d = load || (tvalid_q && !accept);
    tdata_d  = load ? shift_q : tdata_q;
    ferr_d   = done_q && !hist_q[0];
    ovr_d    = good && tvalid_q && !m_axis.tready;
  end

  // state, counters and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      hist_q   <= '0;
      done_q   <= 1'b0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      hist_q   <= hist_d;
      done_q   <= done_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign busy          = state_q inside {START, DATA, STOP};
  assign frame_error   = ferr_q;
  assign overrun_error = ovr_q;
endmodule
